// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline control unit (master) and the hazard controller
// (slave).
//   master drives : decode-stage fields, branch-taken and masked interrupt
//   slave drives  : stall, flush, forwarding selects, interrupt acknowledge
// Optional: when HZ_PERF_CNT_EN is defined the bundle also carries the two
// saturating performance counters (stall cycles, flush cycles).
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
`ifdef HZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  // decode stage
  logic              hz_id_valid;
  logic [REG_AW-1:0] hz_id_addrx;
  logic [REG_AW-1:0] hz_id_addry;
  logic              hz_id_uses_x;
  logic              hz_id_uses_y;
  logic              hz_id_rf_wr;
  logic [1:0]        hz_id_rf_wr_sel;
  // execute / interrupt
  logic              hz_brn_taken;
  logic              hz_intr;
  // controller outputs
  logic              hz_stall;
  logic              hz_flush;
  logic              hz_dec_dx_sel;
  logic              hz_dec_dy_sel;
  logic              hz_ex_dx_sel;
  logic              hz_ex_dy_sel;
  logic              hz_intr_ack;
`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0]  hz_stall_cnt;
  logic [CNT_W-1:0]  hz_flush_cnt;
`endif

  modport master (
    output hz_id_valid, hz_id_addrx, hz_id_addry, hz_id_uses_x, hz_id_uses_y,
           hz_id_rf_wr, hz_id_rf_wr_sel, hz_brn_taken, hz_intr,
    input  hz_stall, hz_flush, hz_dec_dx_sel, hz_dec_dy_sel,
           hz_ex_dx_sel, hz_ex_dy_sel, hz_intr_ack
`ifdef HZ_PERF_CNT_EN
    , input hz_stall_cnt, hz_flush_cnt
`endif
  );

  modport slave (
    input  hz_id_valid, hz_id_addrx, hz_id_addry, hz_id_uses_x, hz_id_uses_y,
           hz_id_rf_wr, hz_id_rf_wr_sel, hz_brn_taken, hz_intr,
    output hz_stall, hz_flush, hz_dec_dx_sel, hz_dec_dy_sel,
           hz_ex_dx_sel, hz_ex_dy_sel, hz_intr_ack
`ifdef HZ_PERF_CNT_EN
    , output hz_stall_cnt, hz_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 4-stage RAT pipeline
// (fetch/decode/execute/writeback). Tracks the destination registers of the
// instructions in execute (E) and writeback (W), produces forwarding selects,
// load-use stalls, branch flushes and the drain-then-acknowledge interrupt
// entry sequence.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   hz     pipe_hazard_ctrl_if.slave (decode fields in, control out)
// Parameters:
//   REG_AW      register address width
//   FLUSH_DEPTH bubbles after a taken branch (1..3), first one Mealy
//   CNT_W       performance counter width (only with HZ_PERF_CNT_EN)
// Optional feature macro: HZ_PERF_CNT_EN adds saturating stall/flush cycle
// counters on the interface.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 2
`ifdef HZ_PERF_CNT_EN
  , parameter int CNT_W     = 16
`endif
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic              wr;
    logic              is_load;
  } slot_t;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ACK} state_t;

  slot_t      e_slot, w_slot;
  state_t     state;
  logic [1:0] flush_left;
  logic       ack_q;
  logic       ex_dx_q, ex_dy_q;

  logic e_hit_x, e_hit_y, w_hit_x, w_hit_y;
  logic load_use, stall, flush, enter, dec_is_load;

  function automatic logic hit(slot_t s, logic [REG_AW-1:0] a);
    return s.valid && s.wr && (s.addr == a);
  endfunction

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    e_hit_x     = hit(e_slot, hz.hz_id_addrx);
    e_hit_y     = hit(e_slot, hz.hz_id_addry);
    w_hit_x     = hit(w_slot, hz.hz_id_addrx);
    w_hit_y     = hit(w_slot, hz.hz_id_addry);
    // scratch (01) and IN_PORT (11) results are only known at writeback
    dec_is_load = hz.hz_id_rf_wr &&
                  (hz.hz_id_rf_wr_sel == 2'b01 || hz.hz_id_rf_wr_sel == 2'b11);
    load_use    = hz.hz_id_valid && e_slot.is_load &&
                  ((hz.hz_id_uses_x && e_hit_x) || (hz.hz_id_uses_y && e_hit_y));
    stall       = 1'b0;
    flush       = 1'b0;
    // a taken branch outranks both the load-use stall and the drain stall
    unique case (state)
      RUN:     if (hz.hz_brn_taken) flush = 1'b1; else stall = load_use;
      FLUSH:   flush = 1'b1;
      DRAIN:   if (hz.hz_brn_taken) flush = 1'b1; else stall = 1'b1;
      ACK:     flush = 1'b1;
      default: ;
    endcase
    enter = hz.hz_id_valid && !stall && !flush;
  end

  assign hz.hz_stall      = stall;
  assign hz.hz_flush      = flush;
  // an E match supersedes W: the execute forward will carry the newer value
  assign hz.hz_dec_dx_sel = hz.hz_id_uses_x && w_hit_x && !e_hit_x;
  assign hz.hz_dec_dy_sel = hz.hz_id_uses_y && w_hit_y && !e_hit_y;
  assign hz.hz_ex_dx_sel  = ex_dx_q;
  assign hz.hz_ex_dy_sel  = ex_dy_q;
  assign hz.hz_intr_ack   = ack_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_slot  <= '0;
      w_slot  <= '0;
      ex_dx_q <= 1'b0;
      ex_dy_q <= 1'b0;
    end else begin
      w_slot  <= e_slot;
      e_slot  <= enter ? slot_t'{1'b1, hz.hz_id_addrx, hz.hz_id_rf_wr, dec_is_load}
                       : slot_t'('0);
      // the producer now in E will be in W when this instruction executes
      ex_dx_q <= enter && hz.hz_id_uses_x && e_hit_x && !e_slot.is_load;
      ex_dy_q <= enter && hz.hz_id_uses_y && e_hit_y && !e_slot.is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_left <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        RUN, DRAIN: begin
          if (hz.hz_brn_taken) begin
            // the branch cycle itself is the first bubble
            state      <= (FLUSH_DEPTH > 1) ? FLUSH : RUN;
            flush_left <= 2'(FLUSH_DEPTH - 1);
          end else if (state == RUN) begin
            if (hz.hz_intr && !load_use) state <= DRAIN;
          end else if (!e_slot.valid && !w_slot.valid) begin
            state <= ACK;
            ack_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_left <= 2'd1) state <= RUN;
          flush_left <= flush_left - 2'd1;
        end
        ACK:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.hz_stall_cnt = stall_cnt;
  assign hz.hz_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives directed test-plan sequences followed by randomized decode traffic,
// branches and interrupts. A behavioural model predicts the outputs of every
// cycle and queues them; a separate monitor pops and compares on each falling
// edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int REG_AW      = 5;
  localparam int FLUSH_DEPTH = 2;
`ifdef HZ_PERF_CNT_EN
  localparam int CNT_W       = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef HZ_PERF_CNT_EN
  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();
  pipe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`else
  pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();
  pipe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH))
    dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit valid;
    int addr;
    bit wr;
    bit ld;
  } inflight_t;

  typedef struct {
    int         cyc;
    logic [6:0] outs;   // {stall, flush, dec_dx, dec_dy, ex_dx, ex_dy, ack}
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t      exp_q[$];
  inflight_t e_m, w_m;
  bit        ex_x_m, ex_y_m, draining_m, ack_m;
  int        flush_left_m, scnt_m, fcnt_m, cyc;

  // current decode-stage stimulus
  bit d_valid, d_ux, d_uy, d_wr, d_brn, d_intr;
  int d_ax, d_ay, d_sel;

  function automatic bit m_hit(inflight_t s, int a);
    return s.valid && s.wr && s.addr == a;
  endfunction

  task automatic model_reset();
    e_m = '{0, 0, 0, 0};
    w_m = '{0, 0, 0, 0};
    ex_x_m = 0; ex_y_m = 0; draining_m = 0; ack_m = 0;
    flush_left_m = 0; scnt_m = 0; fcnt_m = 0;
  endtask

  task automatic model_cycle();
    exp_t x;
    bit lu, st, fl, ex_n, ey_n, enter;
    lu = d_valid && e_m.ld &&
         ((d_ux && m_hit(e_m, d_ax)) || (d_uy && m_hit(e_m, d_ay)));
    st = 0;
    fl = 0;
    if (ack_m || flush_left_m > 0 || d_brn) fl = 1;
    else if (draining_m)                    st = 1;
    else                                    st = lu;
    x.cyc  = cyc;
    x.outs = {st, fl,
              d_ux && m_hit(w_m, d_ax) && !m_hit(e_m, d_ax),
              d_uy && m_hit(w_m, d_ay) && !m_hit(e_m, d_ay),
              ex_x_m, ex_y_m, ack_m};
    x.scnt = scnt_m;
    x.fcnt = fcnt_m;
    exp_q.push_back(x);

    enter = d_valid && !st && !fl;
    ex_n  = enter && d_ux && m_hit(e_m, d_ax) && !e_m.ld;
    ey_n  = enter && d_uy && m_hit(e_m, d_ay) && !e_m.ld;
    if (ack_m) ack_m = 0;
    else if (flush_left_m > 0) flush_left_m--;
    else if (d_brn) begin
      flush_left_m = FLUSH_DEPTH - 1;
      draining_m   = 0;
    end else if (draining_m) begin
      if (!e_m.valid && !w_m.valid) begin
        draining_m = 0;
        ack_m      = 1;
      end
    end else if (d_intr && !lu) draining_m = 1;
    w_m = e_m;
    if (enter) e_m = '{1, d_ax, d_wr, d_wr && (d_sel == 1 || d_sel == 3)};
    else       e_m = '{0, 0, 0, 0};
    ex_x_m = ex_n;
    ex_y_m = ey_n;
    if (st && scnt_m < 65535) scnt_m++;
    if (fl && fcnt_m < 65535) fcnt_m++;
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    hz.hz_id_valid     = d_valid;
    hz.hz_id_addrx     = REG_AW'(d_ax);
    hz.hz_id_addry     = REG_AW'(d_ay);
    hz.hz_id_uses_x    = d_ux;
    hz.hz_id_uses_y    = d_uy;
    hz.hz_id_rf_wr     = d_wr;
    hz.hz_id_rf_wr_sel = 2'(d_sel);
    hz.hz_brn_taken    = d_brn;
    hz.hz_intr         = d_intr;
  endtask

  // one clock with the given decode instruction (valid=0 means empty slot)
  task automatic step(input bit v, input int ax, input int ay, input bit ux, input bit uy,
                      input bit wr, input int sel, input bit brn, input bit intr);
    @(posedge clk);
    #1;
    d_valid = v; d_ax = ax; d_ay = ay;
    d_ux = v && ux; d_uy = v && uy; d_wr = v && wr; d_sel = sel;
    d_brn = brn; d_intr = intr;
    drive();
    model_cycle();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [6:0] dut_outs();
    return {hz.hz_stall, hz.hz_flush, hz.hz_dec_dx_sel, hz.hz_dec_dy_sel,
            hz.hz_ex_dx_sel, hz.hz_ex_dy_sel, hz.hz_intr_ack};
  endfunction

  task automatic apply_reset_and_check(input string name);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_valid = 0; d_ux = 0; d_uy = 0; d_wr = 0; d_brn = 0; d_intr = 0;
    drive();
    #1;
    check({name, " outs"}, 32'(dut_outs()), 32'd0);
`ifdef HZ_PERF_CNT_EN
    check({name, " stall_cnt"}, 32'(hz.hz_stall_cnt), 32'd0);
    check({name, " flush_cnt"}, 32'(hz.hz_flush_cnt), 32'd0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check($sformatf("cyc%0d outs{st,fl,ddx,ddy,edx,edy,ack}", x.cyc),
              32'(dut_outs()), 32'(x.outs));
`ifdef HZ_PERF_CNT_EN
        check($sformatf("cyc%0d stall_cnt", x.cyc), 32'(hz.hz_stall_cnt), 32'(x.scnt));
        check($sformatf("cyc%0d flush_cnt", x.cyc), 32'(hz.hz_flush_cnt), 32'(x.fcnt));
`endif
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit intr_lvl;
    bit v;
    cyc = 0;
    d_valid = 0; d_ux = 0; d_uy = 0; d_wr = 0; d_brn = 0; d_intr = 0;
    d_ax = 0; d_ay = 0; d_sel = 0;
    drive();
    model_reset();
    #2;
    check("reset outs", 32'(dut_outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD r1 ; ADD r2,r1 (Y use) -> execute forward of Y one cycle later
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 2, 1, 0, 1, 1, 0, 0, 0);
    nop(3);
    // ADD r3 ; NOP ; MOV r4,r3 -> decode forward from writeback
    step(1, 3, 0, 0, 0, 1, 0, 0, 0);
    nop(1);
    step(1, 4, 3, 0, 1, 1, 0, 0, 0);
    nop(3);
    // LD r5 (scratch) ; ADD r5,r6 held in decode across the stall
    step(1, 5, 0, 0, 0, 1, 1, 0, 0);
    step(1, 5, 6, 1, 1, 1, 0, 0, 0);
    step(1, 5, 6, 1, 1, 1, 0, 0, 0);
    nop(3);
    // IN_PORT load on Y path
    step(1, 7, 0, 0, 0, 1, 3, 0, 0);
    step(1, 8, 7, 0, 1, 1, 0, 0, 0);
    step(1, 8, 7, 0, 1, 1, 0, 0, 0);
    nop(2);
    // taken branch while instructions are in flight, second pulse ignored
    step(1, 9, 0, 0, 0, 1, 0, 0, 0);
    step(1, 10, 9, 1, 0, 1, 0, 1, 0);
    step(1, 9, 9, 1, 1, 1, 0, 1, 0);
    step(1, 9, 9, 1, 1, 1, 0, 0, 0);
    nop(3);
    // interrupt with E and W occupied
    step(1, 11, 0, 0, 0, 1, 0, 0, 0);
    step(1, 12, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(3);
    // interrupt blocked by load-use, then branch during drain
    step(1, 13, 0, 0, 0, 1, 1, 0, 0);
    step(1, 14, 13, 0, 1, 1, 0, 0, 1);
    step(1, 14, 13, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(4);
    // reset in the middle of a drain
    step(1, 15, 0, 0, 0, 1, 0, 0, 0);
    step(1, 16, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply_reset_and_check("reset_mid_drain");
    nop(2);

    // randomized traffic over a small register window to force hazards
    intr_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) intr_lvl = ~intr_lvl;
      if (i == 1500) begin
        apply_reset_and_check("reset_random");
        intr_lvl = 0;
      end
      v = ($urandom_range(0, 9) < 8);
      step(v, $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 11) == 0, intr_lvl);
    end
    nop(2);
    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 4-stage RAT pipeline (fetch/decode/execute/writeback).
- Keeps a 2-entry scoreboard of in-flight destination registers (execute slot E, writeback slot W).
- Generates forwarding selects for the decode and execute DX/DY forwarding muxes, load-use stalls and flushes after a taken branch.
- Sequences interrupt entry by draining the pipe before acknowledging.

Parameters:
REG_AW, 5, register-file address width (32 regs)
FLUSH_DEPTH, 2, bubbles inserted after a taken branch (1..3)
CNT_W, 16, perf counter width (optional feature only)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
HZ_ID_VALID  in  1  decode stage holds a real instruction
HZ_ID_ADDRX  in  REG_AW  decode source/dest X (instr[12:8])
HZ_ID_ADDRY  in  REG_AW  decode source Y (instr[7:3])
HZ_ID_USES_X  in  1  decode instruction reads X
HZ_ID_USES_Y  in  1  decode instruction reads Y
HZ_ID_RF_WR  in  1  decode instruction writes register X
HZ_ID_RF_WR_SEL  in  2  decode write source: 00 ALU, 01 scratch, 10 SP, 11 IN_PORT
HZ_BRN_TAKEN  in  1  branch/call/ret resolved taken in execute this cycle
HZ_INTR  in  1  masked interrupt request (I flag & INTR)
HZ_STALL  out  1  hold PC and fetch register; inject bubble into decode register
HZ_FLUSH  out  1  invalidate fetch and decode registers
HZ_DEC_DX_SEL, HZ_DEC_DY_SEL  out  1 each  decode mux: 1 = forward writeback data
HZ_EX_DX_SEL, HZ_EX_DY_SEL  out  1 each  execute mux: 1 = forward execute result
HZ_INTR_ACK  out  1  one-cycle pulse: pipe drained, CU may vector to 0x3FF

Behaviour:
- Reset (RST_N=0, async): E and W slots invalid; FSM = RUN; all outputs 0; counters 0.
- Slot entry = {valid, addr, wr, is_load}. is_load = wr && (wr_sel==01 || wr_sel==11).
- Each clock: W<=E. E<=decode fields if HZ_ID_VALID && !HZ_STALL && !HZ_FLUSH, else invalid (bubble).
- Match macros:
  - mE(a) = E.valid && E.wr && E.addr==a
  - mW(a) = W.valid && W.wr && W.addr==a
- HZ_DEC_xx_SEL (combinational) = USES_x && mW(src).
- HZ_EX_xx_SEL (registered) = value of USES_x && mE(src) && !E.is_load captured on the edge the decode instr enters E; cleared when a bubble enters E.
- Priority for a given src: E match beats W match (newest value wins).
- Load-use: USES_x && mE(src) && E.is_load → HZ_STALL=1 for exactly 1 cycle. Next cycle the load is in W, so the DEC forward covers it. Source r0 is not special-cased.
- FSM states and transitions:
  - RUN: asserts combinational load-use stall.
    - HZ_BRN_TAKEN → FLUSH, count=FLUSH_DEPTH-1.
    - else HZ_INTR && !load-use → DRAIN.
  - FLUSH: HZ_FLUSH=1, HZ_STALL=0. Decrement count each cycle; at 0 → RUN.
    - HZ_BRN_TAKEN in FLUSH is ignored: a flushed instr cannot be taken.
  - DRAIN: HZ_STALL=1. No new entries into E.
    - E and W both invalid → ACK.
    - HZ_BRN_TAKEN during DRAIN → FLUSH; the interrupt is re-evaluated afterwards.
  - ACK: HZ_INTR_ACK=1 and HZ_FLUSH=1 for one cycle → RUN.
- Priority: reset > branch flush > load-use stall > interrupt.
- FLUSH on the first cycle: HZ_FLUSH is high in the same cycle as HZ_BRN_TAKEN (Mealy) and for FLUSH_DEPTH cycles total.
- HZ_INTR deasserting during DRAIN: completes to ACK anyway; the CU ignores the late ack only if I is clear.

Optional Feature:
- HZ_PERF_CNT_EN defined: adds outputs HZ_STALL_CNT[CNT_W] and HZ_FLUSH_CNT[CNT_W].
  - Each counts cycles with its signal high.
  - Saturates at all-ones; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD r1 in decode, then ADD r2,r1 next cycle → HZ_EX_DX_SEL... Y-use: HZ_EX_DY_SEL=1 one cycle later, no stall.
- ADD r3 then NOP then MOV r4,r3 → HZ_DEC_DY_SEL=1 while MOV in decode, EX selects 0.
- LD r5 (wr_sel=01) then ADD r5,r6 → HZ_STALL=1 for exactly 1 cycle, then HZ_DEC_DX_SEL=1, E holds a bubble.
- HZ_BRN_TAKEN pulse with FLUSH_DEPTH=2 → HZ_FLUSH high 2 cycles starting same cycle; E/W invalid afterwards, no forwards.
- HZ_INTR with E,W valid → HZ_STALL high 2 cycles, then HZ_INTR_ACK=1 for 1 cycle, then RUN.
- RST_N low mid-DRAIN → all outputs 0 immediately (async), FSM RUN. With HZ_PERF_CNT_EN: HZ_STALL_CNT=0 after reset.
